fp_addsub_seq: RTL and testbench

//  Parametrised multi-cycle floating-point adder/subtractor for the datapath.

---
 rtl/fp_addsub_seq.sv | 175 +++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle FP add/sub: {sign, unbiased exp, explicit mantissa}, align/add/normalise FSM.
// Define FPADD_ROUND_EN for round-to-nearest-even via guard/round/sticky; otherwise truncation.
module fp_addsub_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   funct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Y,
  output logic                   zero,
  output logic                   ovf,
  output logic                   unf
);
  localparam int W = 1 + EXP_W + MAN_W;
`ifdef FPADD_ROUND_EN
  localparam int GW = 3;
`else
  localparam int GW = 0;
`endif
  localparam int XW = MAN_W + GW;  // mantissa plus any guard/round/sticky bits
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, state_n;

  logic             sx, sy, rs;
  logic [EXP_W-1:0] ex, cnt;
  logic [XW-1:0]    mx, my, my_sh;
  logic [XW:0]      sum, sum_sh;

  // operand unpack; zero-mantissa inputs get exponent 0 so they never win the swap
  logic [MAN_W-1:0] am, bm;
  logic [EXP_W-1:0] ae, be, d;
  logic             bs, swap;
  always_comb begin
    am   = A[MAN_W-1:0];
    bm   = B[MAN_W-1:0];
    ae   = (am == '0) ? '0 : A[W-2:MAN_W];
    be   = (bm == '0) ? '0 : B[W-2:MAN_W];
    bs   = B[W-1] ^ funct;
    swap = be > ae;
    d    = swap ? be - ae : ae - be;
  end

  // right shifts keep lost bits in the sticky LSB when rounding is built
  always_comb begin
`ifdef FPADD_ROUND_EN
    my_sh  = {1'b0, my[XW-1:2], my[1] | my[0]};
    sum_sh = {1'b0, sum[XW:2], sum[1] | sum[0]};
`else
    my_sh  = my >> 1;
    sum_sh = sum >> 1;
`endif
  end

  logic         norm_fin, y_zero, y_ovf, y_unf;
  logic [W-1:0] y_n;
`ifdef FPADD_ROUND_EN
  logic [MAN_W:0] rnd;
`endif
  always_comb begin
    norm_fin = 1'b1;
    y_n      = '0;
    y_zero   = 1'b0;
    y_ovf    = 1'b0;
    y_unf    = 1'b0;
`ifdef FPADD_ROUND_EN
    rnd      = '0;
`endif
    if (sum[XW]) begin
      norm_fin = (ex == EMAX);
      y_n      = {rs, {(W-1){1'b1}}};
      y_ovf    = 1'b1;
    end else if (sum == '0) begin
      y_zero = 1'b1;
    end else if (!sum[XW-1]) begin
      norm_fin = (ex == '0);
      y_zero   = 1'b1;
      y_unf    = 1'b1;
    end else begin
`ifdef FPADD_ROUND_EN
      rnd = {1'b0, sum[XW-1:GW]} + (MAN_W+1)'(sum[2] & (sum[1] | sum[0] | sum[GW]));
      if (rnd[MAN_W]) begin
        if (ex == EMAX) begin
          y_n   = {rs, {(W-1){1'b1}}};
          y_ovf = 1'b1;
        end else begin
          y_n = {rs, ex + 1'b1, rnd[MAN_W:1]};
        end
      end else begin
        y_n = {rs, ex, rnd[MAN_W-1:0]};
      end
`else
      y_n = {rs, ex, sum[XW-1:0]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = (d == '0) ? ADD : ALIGN;
      ALIGN:   if (cnt == EXP_W'(1)) state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    if (norm_fin) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= 1'b0; sy <= 1'b0; rs <= 1'b0;
      ex <= '0; cnt <= '0; mx <= '0; my <= '0; sum <= '0;
      Y <= '0; zero <= 1'b0; ovf <= 1'b0; unf <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sx  <= swap ? bs : A[W-1];
          sy  <= swap ? A[W-1] : bs;
          ex  <= swap ? be : ae;
          mx  <= XW'(swap ? bm : am) << GW;
          my  <= XW'(swap ? am : bm) << GW;
          // past MAN_W+2 shifts the smaller mantissa is entirely in sticky already
          cnt <= (int'(d) > MAN_W + 2) ? EXP_W'(MAN_W + 2) : d;
        end
        ALIGN: begin
          my  <= my_sh;
          cnt <= cnt - 1'b1;
        end
        ADD: begin
          if (sx == sy) begin
            sum <= {1'b0, mx} + {1'b0, my};
            rs  <= sx;
          end else if (mx >= my) begin
            sum <= {1'b0, mx - my};
            rs  <= (mx != my) & sx;
          end else begin
            sum <= {1'b0, my - mx};
            rs  <= sy;
          end
        end
        NORM: begin
          if (norm_fin) begin
            Y <= y_n; zero <= y_zero; ovf <= y_ovf; unf <= y_unf;
          end else if (sum[XW]) begin
            sum <= sum_sh;
            ex  <= ex + 1'b1;
          end else begin
            sum <= sum << 1;
            ex  <= ex - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq (EXP_W=3, MAN_W=4) with an arithmetic reference model.
module tb_fp_addsub_seq;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int W = 8;
`ifdef FPADD_ROUND_EN
  localparam int G = 3;
  localparam logic [7:0] RND_Y = 8'h49;
`else
  localparam int G = 0;
  localparam logic [7:0] RND_Y = 8'h48;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, funct, out_valid, out_ready, zero, ovf, unf;
  logic [W-1:0] A, B, Y;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .zero(zero), .ovf(ovf), .unf(unf)
  );

  // value-level model: align by truncation (plus sticky when rounding), add, normalise
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic f,
                       output logic [7:0] y, output logic z, output logic o,
                       output logic u, output int lat);
    int as_, ae, am, bs_, be, bm, xs, xe, xm, ys, ye, ym, al, xv, yv, yfull, v, s, e, k, top, m, low;
    as_ = int'(a[7]); ae = int'(a[6:4]); am = int'(a[3:0]);
    bs_ = int'(b[7] ^ f); be = int'(b[6:4]); bm = int'(b[3:0]);
    if (am == 0) ae = 0;
    if (bm == 0) be = 0;
    if (be > ae) begin xs = bs_; xe = be; xm = bm; ys = as_; ye = ae; ym = am; end
    else         begin xs = as_; xe = ae; xm = am; ys = bs_; ye = be; ym = bm; end
    al = xe - ye;
    if (al > MAN_W + 2) al = MAN_W + 2;
    xv = xm << G;
    yfull = ym << G;
    yv = yfull >> al;
    if (G > 0 && (yfull & ((1 << al) - 1)) != 0) yv = yv | 1;
    if (xs == ys)      begin v = xv + yv; s = xs; end
    else if (xv >= yv) begin v = xv - yv; s = xs; end
    else               begin v = yv - xv; s = ys; end
    top = 1 << (MAN_W + G);
    e = xe; k = 0; z = 0; o = 0; u = 0; y = '0;
    if (v >= top) begin
      if (e == 7) begin o = 1; y = {s[0], 7'h7F}; end
      else begin v = (v >> 1) | ((G > 0) ? (v & 1) : 0); e++; k = 1; end
    end
    if (!o) begin
      if (v == 0) z = 1;
      else begin
        while (v < top / 2 && !u) begin
          if (e == 0) u = 1;
          else begin v = v << 1; e--; k++; end
        end
        if (u) z = 1;
        else begin
          m = v >> G;
          if (G > 0) begin
            low = v & 7;
            if (low > 4 || (low == 4 && (m & 1) != 0)) m++;
            if (m == 16) begin m = 8; if (e == 7) o = 1; else e++; end
          end
          y = o ? {s[0], 7'h7F} : {s[0], e[2:0], m[3:0]};
        end
      end
    end
    lat = 2 + al + k;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic f,
                        output logic [7:0] y, output logic z, output logic o,
                        output logic u, output int lat);
    @(negedge clk);
    A = a; B = b; funct = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    y = Y; z = zero; o = ovf; u = unf;
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct = 1'b0; A = '0; B = '0;
    #1 rst = 1'b1;
    #20;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if ({Y, zero, ovf, unf} !== 11'h0) begin errors++; $display("FAIL reset outputs: got Y=%h z=%b o=%b u=%b want all 0", Y, zero, ovf, unf); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [7:0] ta [6] = '{8'h38, 8'h5C, 8'h38, 8'h78, 8'h0C, 8'h48};
    logic [7:0] tb [6] = '{8'h38, 8'h38, 8'h38, 8'h78, 8'h08, 8'h0F};
    logic       tf [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] ty [6] = '{8'h48, 8'h5A, 8'h00, 8'h7F, 8'h00, RND_Y};
    logic [2:0] tflg [6] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b101, 3'b000};
    int         tlat [6] = '{3, 4, 2, -1, -1, 6};
    logic [7:0] y; logic z, o, u; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tf[i], y, z, o, u, lat);
      checks++; if (y !== ty[i]) begin errors++; $display("FAIL directed[%0d] Y: got %h want %h", i, y, ty[i]); end
      checks++; if ({z, o, u} !== tflg[i]) begin errors++; $display("FAIL directed[%0d] flags zou: got %b want %b", i, {z, o, u}, tflg[i]); end
      if (tlat[i] >= 0) begin
        checks++; if (lat !== tlat[i]) begin errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, tlat[i]); end
      end
      consume();
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] y; logic z, o, u; int lat;
    run_op(8'h5C, 8'h38, 1'b1, y, z, o, u, lat);
    @(negedge clk); A = 8'h11; B = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL hold[%0d] out_valid/in_ready: got %b want 10", i, {out_valid, in_ready}); end
      checks++; if (Y !== 8'h5A) begin errors++; $display("FAIL hold[%0d] Y: got %h want 5a", i, Y); end
    end
    @(negedge clk); in_valid = 1'b0;
    consume();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || Y !== 8'h5A) begin errors++; $display("FAIL after-consume: got out_valid=%b Y=%h want 0/5a", out_valid, Y); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] y, ey; logic z, o, u, ez, eo, eu; int lat, elat;
    run_op(8'h38, 8'h38, 1'b0, y, z, o, u, lat);
    consume();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready after handshake: got %b want 1", in_ready); end
    model(8'h6A, 8'h93, 1'b1, ey, ez, eo, eu, elat);
    run_op(8'h6A, 8'h93, 1'b1, y, z, o, u, lat);
    checks++; if ({y, z, o, u} !== {ey, ez, eo, eu}) begin errors++; $display("FAIL b2b result: got %h/%b%b%b want %h/%b%b%b", y, z, o, u, ey, ez, eo, eu); end
    checks++; if (lat !== elat) begin errors++; $display("FAIL b2b latency: got %0d want %0d", lat, elat); end
    consume();
  endtask

  task automatic test_reset_mid;
    logic [7:0] y, ey; logic z, o, u, ez, eo, eu; int lat, elat, seen;
    @(negedge clk); A = 8'h78; B = 8'h08; funct = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid-op in_ready: got %b want 0", in_ready); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rst-mid out_valid/in_ready: got %b want 01", {out_valid, in_ready}); end
    checks++; if (Y !== 8'h00) begin errors++; $display("FAIL rst-mid Y: got %h want 00", Y); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stale result emitted: got %0d valid cycles want 0", seen); end
    model(8'h2B, 8'h4D, 1'b0, ey, ez, eo, eu, elat);
    run_op(8'h2B, 8'h4D, 1'b0, y, z, o, u, lat);
    checks++; if ({y, z, o, u} !== {ey, ez, eo, eu}) begin errors++; $display("FAIL post-rst result: got %h/%b%b%b want %h/%b%b%b", y, z, o, u, ey, ez, eo, eu); end
    consume();
  endtask

  task automatic test_random;
    logic [7:0] a, b, y, ey; logic f, z, o, u, ez, eo, eu; int lat, elat;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); f = 1'($urandom);
      model(a, b, f, ey, ez, eo, eu, elat);
      run_op(a, b, f, y, z, o, u, lat);
      checks++; if (y !== ey) begin errors++; $display("FAIL rand[%0d] Y (%h %s %h): got %h want %h", i, a, f ? "-" : "+", b, y, ey); end
      checks++; if ({z, o, u} !== {ez, eo, eu}) begin errors++; $display("FAIL rand[%0d] flags zou (%h,%h,%b): got %b want %b", i, a, b, f, {z, o, u}, {ez, eo, eu}); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand[%0d] latency (%h,%h,%b): got %0d want %0d", i, a, b, f, lat, elat); end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
